// File: rtl/nios2_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and per-bit auto-clearing pulse mode.
// Zero-wait writes land on out_port one edge later; readdata is combinational.
module nios2_pio_out_pulse #(
    parameter int unsigned       WIDTH        = 8,
    parameter int unsigned       PULSE_CYCLES = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_active
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_MASK     = 3'd1;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;

    localparam logic [15:0] LOAD_COUNT = 16'(PULSE_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mask;
    logic [15:0]        r_count;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [WIDTH-1:0]   w_mask_nxt;
    logic [15:0]        w_count_nxt;
    logic [WIDTH-1:0]   w_wd;
    logic [WIDTH-1:0]   w_trig_data;
    logic               w_wr;
    logic               w_trig;
    logic               w_unused;

    assign w_wd     = writedata[WIDTH-1:0];
    assign w_wr     = chipselect && !write_n;
    assign w_unused = &{1'b0, writedata};

    // Candidate data value for the three addresses that retrigger the pulse logic.
    always_comb begin
        w_trig      = 1'b0;
        w_trig_data = r_data;
        if (w_wr) begin
            case (address)
                A_DATA: begin
                    w_trig      = 1'b1;
                    w_trig_data = w_wd;
                end
                A_OUTSET: begin
                    w_trig      = 1'b1;
                    w_trig_data = r_data | w_wd;
                end
                A_OUTCLEAR: begin
                    w_trig      = 1'b1;
                    w_trig_data = r_data & ~w_wd;
                end
                default: begin
                    w_trig      = 1'b0;
                    w_trig_data = r_data;
                end
            endcase
        end
    end

    // Next-state: a trigger write takes priority over both countdown and expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;

        if (w_wr && address == A_MASK) begin
            w_mask_nxt = w_wd;
        end

        if (w_trig) begin
            w_data_nxt = w_trig_data;
            if ((w_trig_data & r_mask) != '0) begin
                w_count_nxt = LOAD_COUNT;
                w_state_nxt = S_ACTIVE;
            end else begin
                w_count_nxt = 16'd0;
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_ACTIVE: begin
                    if (r_count == 16'd1) begin
                        w_data_nxt  = r_data & ~r_mask;
                        w_count_nxt = 16'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count - 16'd1;
                        w_state_nxt = S_ACTIVE;
                    end
                end
                default: begin
                    w_count_nxt = 16'd0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= RESET_VALUE;
            r_mask  <= '0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0] = r_data;
            A_MASK:   readdata[WIDTH-1:0] = r_mask;
            A_STATUS: readdata = {r_count, 15'd0, (r_state == S_ACTIVE)};
            default:  readdata = 32'd0;
        endcase
    end

    assign out_port     = r_data;
    assign pulse_active = (r_state == S_ACTIVE);

endmodule

// File: doc/nios2_pio_out_pulse.md
# nios2_pio_out_pulse

Parametrised Avalon-MM output PIO for the Nios II system: drives a WIDTH-bit `out_port` from a software-writable data register. Adds atomic bit-set/bit-clear addresses and a per-bit auto-clearing pulse mode timed by a shared countdown. It sits on the Nios II data master as an `s1` slave, in the same position as the existing 8-bit output PIOs.

## Interface
Parameters:
- `WIDTH`, 8: output port width, 1..32.
- `PULSE_CYCLES`, 16: pulse length in `clk` cycles, 1..65535.
- `RESET_VALUE`, 0: reset value of the data register, `WIDTH` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word address within the slave.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data; bits above `WIDTH` are ignored.
- `readdata` out 32: combinational read data; unused bits are 0.
- `out_port` out WIDTH: the data register.
- `pulse_active` out 1: high while the pulse countdown runs.

## Operation
- Write: `chipselect && !write_n`, sampled at the rising edge, with zero wait states. There is no read strobe; `readdata` is decoded from `address` alone.
- Register map:
  - 0 DATA (R/W): `data <= wd`.
  - 1 PULSE_MASK (R/W): `mask <= wd`. Bits set here are pulse-mode bits.
  - 3 STATUS (RO): bit0 = `pulse_active`; bits[31:16] = current `count`.
  - 4 OUTSET (WO): `data <= data | wd`.
  - 5 OUTCLEAR (WO): `data <= data & ~wd`.
  - 2, 6, 7: reads return 0 and writes are ignored. Reads of 4 and 5 return 0.
- Here `wd` = `writedata[WIDTH-1:0]`.
- State machine: IDLE (`count`==0) and ACTIVE (`count`!=0). `pulse_active` = ACTIVE.
- Trigger on a write to DATA, OUTSET or OUTCLEAR, evaluated on the new data value:
  - new `data & mask` != 0: load `count <= PULSE_CYCLES` and enter ACTIVE. Retriggering in ACTIVE reloads the count.
  - new `data & mask` == 0: `count <= 0` and enter IDLE.
- In ACTIVE with no trigger write: `count <= count-1`.
- Expiry: when `count`==1, the edge performs `data <= data & ~mask` (using the mask at that edge) and `count <= 0`.
- A write to PULSE_MASK changes neither `data` nor `count`.
- Simultaneous events: a trigger write in the expiry cycle wins. The written value is applied with no mask clear, and the count reloads.
- Non-pulse bits (`mask`=0) hold their value indefinitely.

## Timing
- Reset (on an edge with `reset`=1, overriding any write): `data`=`RESET_VALUE`, so `out_port`=`RESET_VALUE`; `mask`=0; `count`=0; `pulse_active`=0.
- `readdata` follows `address` combinationally (0 cycles). The value is the pre-edge value in the same cycle as a write.
- Write latency: a write captured at edge N is visible on `out_port`/`readdata` after N.
- Pulse length: a trigger at edge N gives `count` = PULSE_CYCLES−k after edge N+k. Masked bits clear at edge N+PULSE_CYCLES, so they are high for exactly PULSE_CYCLES cycles. `pulse_active` falls at the same edge.
- `PULSE_CYCLES`=1: load 1 at N, clear at N+1.
- Reset mid-pulse: at the reset edge the countdown aborts and all outputs take their reset values. No expiry occurs afterwards.

## Test plan
- Reset/readback (WIDTH=8, RESET_VALUE=8'hA5):
  - Assert `reset` 2 cycles -> `out_port`=A5, `readdata`@0=0x000000A5, `pulse_active`=0.
  - Write DATA=0x1FF -> `out_port`=FF and `readdata`@0=0x000000FF.
- Set/clear (data=0x0F):
  - Write OUTSET=0x30 -> `out_port`=3F.
  - Then write OUTCLEAR=0x05 -> `out_port`=3A.
  - Read addr 4 -> 0.
- Pulse (PULSE_CYCLES=16, mask=0x01, data=0x80):
  - Write OUTSET=0x01 at edge N -> `out_port`=81 for 16 cycles, then 80 at N+16.
  - `pulse_active` is high over the same window; STATUS reads 0x000F0001 one cycle after N.
- Retrigger and collision: with the pulse above, write OUTSET=0x01 at edges N+10 and N+26.
  - The first write extends the clear to edge N+26.
  - The write at N+26 (the expiry edge) wins: bit stays 1 and clears at N+42.
- Early cancel and reset:
  - OUTCLEAR=0x01 at N+5 -> `pulse_active`=0 at N+5 and no later clear of newly written non-pulse bits.
  - Separately, `reset` at N+3 -> `out_port`=RESET_VALUE, `count`=0, with no expiry at N+16.
